// File: rtl/dtw_stream_ctrl.sv
// DTW sequencing controller: loads a reference from a FWFT source FIFO, streams
// queries into the DTW datapath and writes 3-word result packets to a sink FIFO.
module dtw_stream_ctrl #(
    parameter int WIDTH        = 16,
    parameter int PTR_W        = 20,
    parameter int QLEN_W       = 10,
    parameter int DRAIN_MARGIN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              keep_ref,
    input  logic [PTR_W-1:0]  ref_len,
    input  logic [QLEN_W-1:0] qry_len,
    input  logic [15:0]       num_queries,
    input  logic [WIDTH-1:0]  threshold,
    output logic              busy,
    output logic              ref_valid,
    output logic              src_rden,
    input  logic              src_empty,
    input  logic [31:0]       src_data,
    output logic              ref_wen,
    output logic [PTR_W-1:0]  ref_addr,
    output logic [WIDTH-1:0]  ref_din,
    output logic              dp_rst,
    output logic              dp_run,
    output logic [WIDTH-1:0]  dp_sample,
    input  logic              dp_done,
    input  logic [WIDTH-1:0]  dp_minval,
    input  logic [31:0]       dp_position,
    output logic              sink_wren,
    input  logic              sink_full,
    output logic [31:0]       sink_data,
    output logic              sink_last,
    output logic [31:0]       nquery,
    output logic [2:0]        dbg_state
);
    localparam int CW = PTR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REF   = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_RES   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [PTR_W-1:0]  ref_len_q, ref_len_d;
    logic [QLEN_W-1:0] qry_len_q, qry_len_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       batch_q, batch_d;
    logic [WIDTH-1:0]  thr_q, thr_d;
    logic              ref_valid_q, ref_valid_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       qid_q, qid_d;
    logic [WIDTH-1:0]  minval_q, minval_d;
    logic [31:0]       pos_q, pos_d;
    logic              timeout_q, timeout_d;
    logic [1:0]        widx_q, widx_d;
    logic [31:0]       nquery_q, nquery_d;
    logic              ref_wen_q, ref_wen_d;
    logic [PTR_W-1:0]  ref_addr_q, ref_addr_d;
    logic [WIDTH-1:0]  ref_din_q, ref_din_d;
    logic              dp_rst_q, dp_rst_d;
    logic              dp_run_q, dp_run_d;
    logic [WIDTH-1:0]  dp_sample_q, dp_sample_d;
    logic              sink_wren_q, sink_wren_d;
    logic [31:0]       sink_data_q, sink_data_d;
    logic              sink_last_q, sink_last_d;

    logic [PTR_W-1:0]  addr_inc;
    logic              last_query;
    logic              match;
    logic [31:0]       word2;

    assign src_rden   = !src_empty && !abort &&
                        (state_q == S_REF || state_q == S_HDR || state_q == S_LOAD);
    assign addr_inc   = (ref_addr_q == '1) ? ref_addr_q : ref_addr_q + 1'b1;
    assign last_query = (num_q != 16'd0) && (batch_q + 16'd1 == num_q);
    assign match      = !timeout_q && (minval_q <= thr_q);
    assign word2      = {match, timeout_q, {(30-WIDTH){1'b0}}, minval_q};

    always_comb begin
        state_d     = state_q;
        ref_len_d   = ref_len_q;
        qry_len_d   = qry_len_q;
        num_d       = num_q;
        batch_d     = batch_q;
        thr_d       = thr_q;
        ref_valid_d = ref_valid_q;
        cnt_d       = cnt_q;
        qid_d       = qid_q;
        minval_d    = minval_q;
        pos_d       = pos_q;
        timeout_d   = timeout_q;
        widx_d      = widx_q;
        nquery_d    = nquery_q;
        ref_wen_d   = 1'b0;
        ref_addr_d  = ref_addr_q;
        ref_din_d   = ref_din_q;
        dp_rst_d    = 1'b0;
        dp_run_d    = 1'b0;
        dp_sample_d = dp_sample_q;
        sink_wren_d = 1'b0;
        sink_data_d = sink_data_q;
        sink_last_d = 1'b0;
        if (abort) begin
            // Everything in flight, including a partly written packet, is dropped.
            state_d  = S_IDLE;
            dp_rst_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dp_rst_d = 1'b1;
                    if (start) begin
                        ref_len_d = ref_len;
                        qry_len_d = (qry_len == '0) ? QLEN_W'(1) : qry_len;
                        num_d     = num_queries;
                        thr_d     = threshold;
                        batch_d   = 16'd0;
                        cnt_d     = '0;
                        if (keep_ref && ref_valid_q) begin
                            state_d = S_HDR;
                        end else if (ref_len != '0) begin
                            ref_valid_d = 1'b0;
                            state_d     = S_REF;
                        end
                    end
                end
                S_REF: if (src_rden) begin
                    ref_wen_d  = 1'b1;
                    ref_addr_d = cnt_q[PTR_W-1:0];
                    ref_din_d  = src_data[WIDTH-1:0];
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CW'(ref_len_q) - CW'(1)) begin
                        ref_valid_d = 1'b1;
                        state_d     = S_HDR;
                    end
                end
                S_HDR: if (src_rden) begin
                    qid_d      = src_data;
                    dp_rst_d   = 1'b1;
                    ref_addr_d = '0;
                    cnt_d      = '0;
                    state_d    = S_LOAD;
                end
                S_LOAD: begin
                    if (dp_run_q) ref_addr_d = addr_inc;
                    if (src_rden) begin
                        dp_run_d    = 1'b1;
                        dp_sample_d = src_data[WIDTH-1:0];
                        cnt_d       = cnt_q + 1'b1;
                        if (cnt_q == CW'(qry_len_q) - CW'(1)) begin
                            cnt_d   = '0;
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (dp_run_q) ref_addr_d = addr_inc;
                    // cnt_q counts drain beats already issued after the last sample.
                    if (dp_done) begin
                        minval_d  = dp_minval;
                        pos_d     = dp_position;
                        timeout_d = 1'b0;
                        widx_d    = 2'd0;
                        state_d   = S_RES;
                    end else if (cnt_q == CW'(ref_len_q) + CW'(DRAIN_MARGIN)) begin
                        minval_d  = '1;
                        pos_d     = '1;
                        timeout_d = 1'b1;
                        widx_d    = 2'd0;
                        state_d   = S_RES;
                    end else begin
                        dp_run_d = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                S_RES: if (!sink_full) begin
                    sink_wren_d = 1'b1;
                    case (widx_q)
                        2'd0:    sink_data_d = qid_q;
                        2'd1:    sink_data_d = pos_q;
                        default: sink_data_d = word2;
                    endcase
                    if (widx_q == 2'd2) begin
                        sink_last_d = last_query;
                        nquery_d    = nquery_q + 32'd1;
                        batch_d     = batch_q + 16'd1;
                        widx_d      = 2'd0;
                        if (num_q == 16'd0 || !last_query) begin
                            state_d = S_HDR;
                        end else begin
                            state_d  = S_IDLE;
                            dp_rst_d = 1'b1;
                        end
                    end else begin
                        widx_d = widx_q + 2'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ref_len_q   <= '0;
            qry_len_q   <= '0;
            num_q       <= '0;
            batch_q     <= '0;
            thr_q       <= '0;
            ref_valid_q <= 1'b0;
            cnt_q       <= '0;
            qid_q       <= '0;
            minval_q    <= '0;
            pos_q       <= '0;
            timeout_q   <= 1'b0;
            widx_q      <= '0;
            nquery_q    <= '0;
            ref_wen_q   <= 1'b0;
            ref_addr_q  <= '0;
            ref_din_q   <= '0;
            dp_rst_q    <= 1'b1;
            dp_run_q    <= 1'b0;
            dp_sample_q <= '0;
            sink_wren_q <= 1'b0;
            sink_data_q <= '0;
            sink_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_len_q   <= ref_len_d;
            qry_len_q   <= qry_len_d;
            num_q       <= num_d;
            batch_q     <= batch_d;
            thr_q       <= thr_d;
            ref_valid_q <= ref_valid_d;
            cnt_q       <= cnt_d;
            qid_q       <= qid_d;
            minval_q    <= minval_d;
            pos_q       <= pos_d;
            timeout_q   <= timeout_d;
            widx_q      <= widx_d;
            nquery_q    <= nquery_d;
            ref_wen_q   <= ref_wen_d;
            ref_addr_q  <= ref_addr_d;
            ref_din_q   <= ref_din_d;
            dp_rst_q    <= dp_rst_d;
            dp_run_q    <= dp_run_d;
            dp_sample_q <= dp_sample_d;
            sink_wren_q <= sink_wren_d;
            sink_data_q <= sink_data_d;
            sink_last_q <= sink_last_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign ref_valid = ref_valid_q;
    assign ref_wen   = ref_wen_q;
    assign ref_addr  = ref_addr_q;
    assign ref_din   = ref_din_q;
    assign dp_rst    = dp_rst_q;
    assign dp_run    = dp_run_q;
    assign dp_sample = dp_sample_q;
    assign sink_wren = sink_wren_q;
    assign sink_data = sink_data_q;
    assign sink_last = sink_last_q;
    assign nquery    = nquery_q;
    assign dbg_state = state_q;

endmodule

// File: doc/dtw_stream_ctrl.md
Name: dtw_stream_ctrl

Overview:
Next-generation DTW sequencing controller that drives the external reference memory and DTW datapath from a FWFT source FIFO.
- Persistent reference: a loaded reference is reused across starts via keep_ref.
- Runtime query length, up to 2^QLEN_W-1 samples.
- Batches of N queries per start, or continuous mode.
- Match thresholding against a runtime threshold.
- Drain timeout and mid-run abort.
- Results go to a 32-bit sink FIFO as 3-word packets.

Parameters:
WIDTH, 16, sample and score width (2..29)
PTR_W, 20, reference address width
QLEN_W, 10, query length field width
DRAIN_MARGIN, 16, extra run beats allowed after the last sample before timeout

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; honoured only in IDLE
abort  in  1  level; returns to IDLE
keep_ref  in  1  1 = skip the reference load if ref_valid
ref_len  in  PTR_W  reference length in samples
qry_len  in  QLEN_W  samples per query
num_queries  in  16  queries per batch; 0 = continuous
threshold  in  WIDTH  match threshold
busy  out  1  high in every state except IDLE
ref_valid  out  1  reference memory holds a complete reference
src_rden  out  1  pop the source FIFO (combinational)
src_empty  in  1  source FIFO empty
src_data  in  32  FWFT source head word
ref_wen  out  1  reference memory write enable
ref_addr  out  PTR_W  reference memory address
ref_din  out  WIDTH  reference memory write data
dp_rst  out  1  datapath reset
dp_run  out  1  datapath advance beat
dp_sample  out  WIDTH  query sample presented to the datapath
dp_done  in  1  datapath result valid
dp_minval  in  WIDTH  best score
dp_position  in  32  best match position
sink_wren  out  1  sink FIFO write
sink_full  in  1  sink FIFO full
sink_data  out  32  sink FIFO word
sink_last  out  1  final word of the batch
nquery  out  32  count of completed queries since reset

Behaviour:
Reset values:
- All registered outputs are 0, except dp_rst=1.
- State is IDLE; ref_valid=0; nquery=0.

Source handshake:
- src_rden = !src_empty && state in {REF_LOAD, Q_HDR, Q_LOAD} && !abort.
- A word is consumed in any cycle where src_rden=1.

States: IDLE, REF_LOAD, Q_HDR, Q_LOAD, Q_DRAIN, RESULT.

IDLE:
- dp_rst=1, dp_run=0.
- On start:
  - keep_ref && ref_valid -> Q_HDR.
  - Otherwise, if ref_len==0 -> stay in IDLE.
  - Otherwise -> ref_valid<=0, REF_LOAD.
- Input latching:
  - ref_len is latched at start.
  - qry_len, num_queries and threshold are latched at start and are stable for the whole batch.
- qry_len==0 is treated as 1.

REF_LOAD:
- Each consumed word k (0-based) produces, on the next cycle: ref_wen=1, ref_addr=k, ref_din=src_data[WIDTH-1:0].
- After word ref_len-1 is consumed -> ref_valid<=1 one cycle later, then Q_HDR.

Q_HDR:
- Consuming a word latches qid = the full 32 bits.
- Next cycle: dp_rst=1 for exactly one cycle, ref_addr<=0, sample counter cleared, then Q_LOAD.

Q_LOAD:
- Each consumed word -> next cycle dp_run=1, dp_sample=src_data[WIDTH-1:0], ref_addr increments after each beat.
- An empty FIFO stalls: dp_run=0, nothing advances.
- After qry_len samples -> Q_DRAIN.

Q_DRAIN:
- dp_run=1 every cycle; ref_addr keeps incrementing, saturating at 2^PTR_W-1.
- dp_done sampled high -> latch dp_minval and dp_position, go to RESULT, timeout=0.
- Timeout: drain beats reach ref_len+DRAIN_MARGIN without dp_done -> RESULT with timeout=1, minval=all ones, position=0xFFFFFFFF.
- dp_done seen during Q_LOAD is ignored.

RESULT:
- dp_run=0.
- Emits word0=qid, word1=position, word2={match, timeout, zeros, minval[WIDTH-1:0]}, with match at bit31 and timeout at bit30.
- match = !timeout && (minval <= threshold).
- Writes: a word is written, registered (sink_wren=1 next cycle), only in cycles where sink_full=0; sink_full=1 holds the word index.
- sink_last=1 with word2 iff num_queries!=0 and this is query num_queries of the batch.
- nquery increments with word2.
- After word2: if more queries remain or continuous mode -> Q_HDR; else -> IDLE.

abort:
- Takes priority over all transitions; next state is IDLE.
- An in-flight result packet is dropped without sink_last.
- An abort in REF_LOAD leaves ref_valid=0; otherwise ref_valid is kept.

Other rules:
- start while busy is ignored.
- rst mid-operation returns everything to reset values, including ref_valid=0.

Test Plan:
1. ref_len=4, refs 1..4, qry_len=2, num_queries=1, qid=0x55, datapath model returns minval=3, pos=7, threshold=5 -> ref writes at addr 0..3; sink: 0x55, 7, 0x80000003 with sink_last on the third word; nquery=1; busy low after.
2. Second start with keep_ref=1 -> no ref_wen pulses; first src pop is the qid; same packet format.
3. num_queries=3, src_empty toggling every other cycle, sink_full high for 5 cycles mid-packet -> 9 words in order, no duplicates or loss, sink_last only on word 9, dp_run count per query = qry_len + drain beats.
4. dp_done never asserted, ref_len=4, DRAIN_MARGIN=16 -> after 20 drain beats, word2=0x4000FFFF and word1=0xFFFFFFFF.
5. abort during REF_LOAD at word 2 -> IDLE next cycle, ref_valid=0; a subsequent keep_ref start reloads. abort during Q_LOAD -> ref_valid stays 1, no sink writes.
6. minval=threshold+1 -> bit31=0; minval=threshold -> bit31=1; num_queries=0 -> packets continue with sink_last never set until abort.
